seq_restoring_divider_32b: RTL and testbench

- Iterative 32-bit unsigned restoring divider for the execute stage.
- Sits directly upstream of the shared 32-bit Kogge-Stone adder/subtractor. Each cycle it drives one trial subtraction into that adder and consumes the adder's sum and carry-out to decide the quotient bit.
- Frees the ALU from a dedicated divider array; the result is handed to writeback via a done pulse.

---
 rtl/seq_restoring_divider_32b.sv | 153 +++++++++++++++
 tb/tb_seq_restoring_divider_32b.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/seq_restoring_divider_32b.sv
// Iterative 32-bit restoring divider driving the shared adder/subtractor, one quotient bit per cycle.
// Optional macro SIGNED_DIV_EN adds is_signed and a sign-fixup state after the iterations.
module seq_restoring_divider_32b #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned CNT_W = 6
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
`ifdef SIGNED_DIV_EN
   input  logic             is_signed,
`endif
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero,
   output logic [WIDTH-1:0] add_a,
   output logic [WIDTH-1:0] add_b,
   output logic             add_s,
   input  logic [WIDTH-1:0] add_sum,
   input  logic             add_cout
);

`ifdef SIGNED_DIV_EN
   typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX, S_DONE} state_t;
`else
   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
`endif

   state_t           state;
   logic [WIDTH-1:0] rem;
   logic [WIDTH-1:0] q;
   logic [WIDTH-1:0] d;
   logic [CNT_W-1:0] cnt;
   logic [WIDTH-1:0] shifted;
   logic [WIDTH-1:0] rem_nxt;
   logic [WIDTH-1:0] q_nxt;
   logic             accept;
   logic [WIDTH-1:0] dividend_mag;
   logic [WIDTH-1:0] divisor_mag;

`ifdef SIGNED_DIV_EN
   logic sgn_op;
   logic neg_q;
   logic neg_r;

   assign dividend_mag = (is_signed && dividend[WIDTH-1]) ? -dividend : dividend;
   assign divisor_mag  = (is_signed && divisor[WIDTH-1])  ? -divisor  : divisor;
`else
   assign dividend_mag = dividend;
   assign divisor_mag  = divisor;
`endif

   // rem[31] set means the shifted value is >= 2^32 > d, so the trial always succeeds
   assign shifted = {rem[WIDTH-2:0], q[WIDTH-1]};
   assign accept  = rem[WIDTH-1] | add_cout;
   assign rem_nxt = accept ? add_sum : shifted;
   assign q_nxt   = {q[WIDTH-2:0], accept};

   assign add_a = shifted;
   assign add_b = d;
   assign add_s = 1'b1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= S_IDLE;
         rem         <= '0;
         q           <= '0;
         d           <= '0;
         cnt         <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         quotient    <= '0;
         remainder   <= '0;
         div_by_zero <= 1'b0;
`ifdef SIGNED_DIV_EN
         sgn_op      <= 1'b0;
         neg_q       <= 1'b0;
         neg_r       <= 1'b0;
`endif
      end else begin
         done <= 1'b0;
         unique case (state)
            S_IDLE: begin
               if (start) begin
                  if (divisor == '0) begin
                     quotient    <= '1;
                     remainder   <= dividend;
                     div_by_zero <= 1'b1;
                     done        <= 1'b1;
                     state       <= S_DONE;
                  end else begin
                     rem         <= '0;
                     q           <= dividend_mag;
                     d           <= divisor_mag;
                     cnt         <= '0;
                     div_by_zero <= 1'b0;
                     busy        <= 1'b1;
                     state       <= S_RUN;
`ifdef SIGNED_DIV_EN
                     sgn_op      <= is_signed;
                     neg_q       <= is_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                     neg_r       <= is_signed & dividend[WIDTH-1];
`endif
                  end
               end
            end
            S_RUN: begin
               rem <= rem_nxt;
               q   <= q_nxt;
               cnt <= cnt + CNT_W'(1);
               if (cnt == CNT_W'(WIDTH - 1)) begin
                  busy <= 1'b0;
`ifdef SIGNED_DIV_EN
                  if (sgn_op) begin
                     state <= S_FIX;
                  end else begin
                     quotient  <= q_nxt;
                     remainder <= rem_nxt;
                     done      <= 1'b1;
                     state     <= S_DONE;
                  end
`else
                  quotient  <= q_nxt;
                  remainder <= rem_nxt;
                  done      <= 1'b1;
                  state     <= S_DONE;
`endif
               end
            end
`ifdef SIGNED_DIV_EN
            // Two's-complement negation also maps 0x80000000 / -1 onto 0x80000000
            S_FIX: begin
               quotient  <= neg_q ? -q : q;
               remainder <= neg_r ? -rem : rem;
               done      <= 1'b1;
               state     <= S_DONE;
            end
`endif
            S_DONE: begin
               state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_seq_restoring_divider_32b.sv
// Randomised self-checking bench for seq_restoring_divider_32b with a behavioural adder and divide model.
// Signed cases run only when SIGNED_DIV_EN is defined.
module tb_seq_restoring_divider_32b;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [31:0] dividend = '0;
   logic [31:0] divisor = '0;
`ifdef SIGNED_DIV_EN
   logic        is_signed = 1'b0;
`endif
   logic        busy, done, div_by_zero, add_s, add_cout;
   logic [31:0] quotient, remainder, add_a, add_b, add_sum;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   // Shared adder in subtract mode: a + ~b + 1
   assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, ~add_b} + 33'd1;

   seq_restoring_divider_32b dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .dividend    (dividend),
      .divisor     (divisor),
`ifdef SIGNED_DIV_EN
      .is_signed   (is_signed),
`endif
      .busy        (busy),
      .done        (done),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero),
      .add_a       (add_a),
      .add_b       (add_b),
      .add_s       (add_s),
      .add_sum     (add_sum),
      .add_cout    (add_cout)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   task automatic ref_div(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                          output logic [31:0] q, output logic [31:0] r);
      if (b == 32'd0) begin
         q = 32'hFFFF_FFFF;
         r = a;
      end else if (sgn) begin
         if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000;
            r = 32'd0;
         end else begin
            q = 32'($signed(a) / $signed(b));
            r = 32'($signed(a) % $signed(b));
         end
      end else begin
         q = a / b;
         r = a % b;
      end
   endtask

   // early: raise start during the DONE cycle of the previous op and hold it into IDLE
   task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                         input bit inject, input bit early);
      logic [31:0] eq, er, eb;
      int exp_lat, cyc;
      ref_div(a, b, sgn, eq, er);
      exp_lat = (b == 32'd0) ? 1 : (sgn ? 34 : 33);
      eb = (sgn && b[31]) ? -b : b;
      if (!early) @(negedge clk);
      start = 1'b1;
      dividend = a;
      divisor = b;
`ifdef SIGNED_DIV_EN
      is_signed = sgn;
`endif
      if (early) @(negedge clk);
      @(posedge clk);
      #1 start = 1'b0;
      cyc = 1;
      @(negedge clk);
      if (b != 32'd0) begin
         check("busy_run", 32'(busy), 32'd1);
         check("add_s_run", 32'(add_s), 32'd1);
         check("add_b_run", add_b, eb);
      end
      while (!done && cyc < 60) begin
         if (inject && cyc == 10) begin
            start = 1'b1;
            dividend = 32'd50;
            divisor = 32'd5;
         end else begin
            start = 1'b0;
         end
         @(negedge clk);
         cyc++;
      end
      start = 1'b0;
      check("latency", 32'(cyc), 32'(exp_lat));
      check("quotient", quotient, eq);
      check("remainder", remainder, er);
      check("div_by_zero", 32'(div_by_zero), 32'(b == 32'd0));
      check("busy_done", 32'(busy), 32'd0);
   endtask

   initial begin
      logic [31:0] a, b;
      int ndone;

      #12 ;
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_quot", quotient, 32'd0);
      check("rst_rem", remainder, 32'd0);
      check("rst_dbz", 32'(div_by_zero), 32'd0);
      check("rst_add_a", add_a, 32'd0);
      check("rst_add_b", add_b, 32'd0);
      rst_n = 1'b1;

      run_op(32'd100, 32'd7, 1'b0, 1'b0, 1'b0);
      run_op(32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0, 1'b0);
      run_op(32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 1'b0, 1'b0);
      run_op(32'd5, 32'd0, 1'b0, 1'b0, 1'b0);
      run_op(32'd9, 32'd3, 1'b0, 1'b0, 1'b0);
      run_op(32'd100, 32'd7, 1'b0, 1'b1, 1'b0);
      run_op(32'd20, 32'd6, 1'b0, 1'b0, 1'b1);
      run_op(32'd0, 32'd0, 1'b0, 1'b0, 1'b1);

      for (int i = 0; i < 20; i++) begin
         a = $urandom;
         b = $urandom >> $urandom_range(0, 31);
         if ($urandom_range(0, 9) == 0) b = 32'd0;
         run_op(a, b, 1'b0, 1'b0, 1'b0);
      end

`ifdef SIGNED_DIV_EN
      run_op(32'hFFFF_FFF9, 32'd2, 1'b1, 1'b0, 1'b0);
      run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);
      run_op(32'hFFFF_FFF9, 32'd0, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 12; i++) begin
         a = $urandom;
         b = 32'($signed($urandom) >>> $urandom_range(0, 31));
         if (b == 32'd0) b = 32'd3;
         run_op(a, b, 1'(i % 2), 1'b0, 1'b0);
      end
`endif

      // Reset in the middle of a run aborts with no done
      @(negedge clk);
      start = 1'b1;
      dividend = 32'd100;
      divisor = 32'd7;
`ifdef SIGNED_DIV_EN
      is_signed = 1'b0;
`endif
      @(posedge clk);
      #1 start = 1'b0;
      for (int i = 0; i < 15; i++) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_done", 32'(done), 32'd0);
      check("abort_quot", quotient, 32'd0);
      check("abort_rem", remainder, 32'd0);
      check("abort_dbz", 32'(div_by_zero), 32'd0);
      check("abort_add_b", add_b, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      ndone = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (done) ndone++;
      end
      check("abort_no_done", 32'(ndone), 32'd0);
      check("abort_quot_hold", quotient, 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
